// File: rtl/wts_channel_sequencer_if.sv
// Bundles the sequencer's sample-tick, selector and wave-RAM signals.
// slave: the sequencer side. master: the register file / selector / RAM side.
interface wts_channel_sequencer_if #(
   parameter int FREQ_BITS = 12
);
   logic                 tick;
   logic [4:0]           key_on;
   logic [FREQ_BITS-1:0] freq;
   logic [2:0]           active;
   logic                 busy;
   logic [7:0]           wave_address;
   logic                 address_valid;
   logic                 frame_done;
   logic                 overrun;

   modport master (
      output tick, key_on, freq,
      input  active, busy, wave_address, address_valid, frame_done, overrun
   );

   modport slave (
      input  tick, key_on, freq,
      output active, busy, wave_address, address_valid, frame_done, overrun
   );
endinterface

// File: rtl/wts_channel_sequencer.sv
// Time-multiplexed phase sequencer for the 5-channel wave table engine.
// Each sample tick walks channels 0..4 through SELECT/CALC/EMIT, updates that
// channel's divider counter and wave pointer, and emits one wave-RAM address.
// Optional feature macro: WTS_SEQ_OVERRUN_EN (1-deep tick pending flag plus
// sticky overrun). Without it, ticks arriving mid-frame are dropped.
module wts_channel_sequencer #(
   parameter int FREQ_BITS = 12,
   parameter int MIN_FREQ  = 9
) (
   input  logic                    clk,
   input  logic                    nreset,
   wts_channel_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SELECT, CALC, EMIT} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [2:0]           ch;
   logic [2:0]           ch_nxt;
   logic                 start;
   logic                 pending;
   logic                 overrun_q;

   logic [FREQ_BITS-1:0] freq_p0;
   logic [FREQ_BITS-1:0] cnt [0:4];
   logic [4:0]           ptr [0:4];
   logic [FREQ_BITS-1:0] cnt_cur;
   logic [FREQ_BITS-1:0] cnt_upd;
   logic [4:0]           ptr_cur;
   logic [4:0]           ptr_upd;

   assign start = (state == IDLE) && (bus.tick || pending);

   // State and channel index register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state <= IDLE;
         ch    <= 3'd0;
      end else begin
         state <= state_nxt;
         ch    <= ch_nxt;
      end
   end

   // Next-state: three slots per channel, back to IDLE after channel 4 emits
   always_comb begin
      state_nxt = state;
      ch_nxt    = ch;
      case (state)
         IDLE: begin
            ch_nxt = 3'd0;
            if (start) state_nxt = SELECT;
         end
         SELECT: state_nxt = CALC;
         CALC:   state_nxt = EMIT;
         EMIT: begin
            if (ch == 3'd4) begin
               state_nxt = IDLE;
               ch_nxt    = 3'd0;
            end else begin
               state_nxt = SELECT;
               ch_nxt    = ch + 3'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            ch_nxt    = 3'd0;
         end
      endcase
   end

   // Capture the selector's frequency at the end of the channel's SELECT slot
   always_ff @(posedge clk) begin
      if (state == SELECT) freq_p0 <= bus.freq;
   end

   // Divider/pointer update for the channel currently in CALC
   always_comb begin
      cnt_cur = cnt[ch];
      ptr_cur = ptr[ch];
      cnt_upd = cnt_cur;
      ptr_upd = ptr_cur;
      if (!bus.key_on[ch]) begin
         cnt_upd = freq_p0;
         ptr_upd = 5'd0;
      end else if (freq_p0 < FREQ_BITS'(MIN_FREQ)) begin
         cnt_upd = cnt_cur;
         ptr_upd = ptr_cur;
      end else if (cnt_cur == '0) begin
         cnt_upd = freq_p0;
         ptr_upd = ptr_cur + 5'd1;
      end else begin
         cnt_upd = cnt_cur - 1'b1;
      end
   end

   // Per-channel counter/pointer storage, written once per frame in CALC
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < 5; i++) begin
            cnt[i] <= '0;
            ptr[i] <= 5'd0;
         end
      end else if (state == CALC) begin
         cnt[ch] <= cnt_upd;
         ptr[ch] <= ptr_upd;
      end
   end

`ifdef WTS_SEQ_OVERRUN_EN
   // One-deep pending tick; a second tick while one is pending is an overrun
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         pending   <= 1'b0;
         overrun_q <= 1'b0;
      end else if (start) begin
         pending <= 1'b0;
      end else if (bus.tick && (state != IDLE)) begin
         if (pending) overrun_q <= 1'b1;
         pending <= 1'b1;
      end
   end
`else
   assign pending   = 1'b0;
   assign overrun_q = 1'b0;
`endif

   assign bus.active        = ch;
   assign bus.busy          = (state != IDLE);
   assign bus.address_valid = (state == EMIT);
   assign bus.wave_address  = (state == EMIT) ? {ch, ptr[ch]} : 8'h00;
   assign bus.frame_done    = (state == EMIT) && (ch == 3'd4);
   assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_wts_channel_sequencer.sv
// Directed bench for wts_channel_sequencer: per-cycle frame table plus
// hand-written reset, divide, halt, wrap and overrun sequences.
module tb_wts_channel_sequencer;

   logic clk;
   logic nreset;
   logic [11:0] chan_freq [0:4];
   logic [7:0]  frame_addr [0:4];
   int tests;
   int fails;

   typedef struct {
      logic       tick;
      logic [2:0] act;
      logic       busy;
      logic       valid;
      logic [7:0] addr;
      logic       done;
   } vec_t;

   vec_t vec [0:16];

   wts_channel_sequencer_if #(.FREQ_BITS(12)) ifc ();

   wts_channel_sequencer #(.FREQ_BITS(12), .MIN_FREQ(9)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behaves like the register-file selector: freq of the active channel
   always_comb begin
      ifc.freq = 12'h000;
      if (ifc.active < 3'd5) ifc.freq = chan_freq[ifc.active];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      nreset = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
   endtask

   // One tick, then follow the frame until busy drops; addresses recorded in order
   task automatic run_frame();
      int n;
      int cyc;
      n = 0;
      cyc = 0;
      for (int i = 0; i < 5; i++) frame_addr[i] = 8'hxx;
      @(negedge clk);
      ifc.tick = 1'b1;
      @(negedge clk);
      ifc.tick = 1'b0;
      while (ifc.busy && cyc < 30) begin
         if (ifc.address_valid) begin
            if (n < 5) frame_addr[n] = ifc.wave_address;
            n++;
         end
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 30 || n != 5) begin
         tests++;
         fails++;
         $display("FAIL run_frame: cycles %0d valids %0d, required <30 and 5", cyc, n);
      end
   endtask

   initial begin
      int vcount;
      int dcount;
      tests = 0;
      fails = 0;
      nreset = 1'b0;
      ifc.tick = 1'b0;
      ifc.key_on = 5'b00000;
      for (int i = 0; i < 5; i++) chan_freq[i] = 12'h000;

      vec[0]  = '{1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0};
      vec[1]  = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0};
      vec[2]  = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0};
      vec[3]  = '{1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0};
      vec[4]  = '{1'b0, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0};
      vec[5]  = '{1'b0, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0};
      vec[6]  = '{1'b0, 3'd1, 1'b1, 1'b1, 8'h20, 1'b0};
      vec[7]  = '{1'b0, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0};
      vec[8]  = '{1'b0, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0};
      vec[9]  = '{1'b0, 3'd2, 1'b1, 1'b1, 8'h40, 1'b0};
      vec[10] = '{1'b0, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0};
      vec[11] = '{1'b0, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0};
      vec[12] = '{1'b0, 3'd3, 1'b1, 1'b1, 8'h60, 1'b0};
      vec[13] = '{1'b0, 3'd4, 1'b1, 1'b0, 8'h00, 1'b0};
      vec[14] = '{1'b0, 3'd4, 1'b1, 1'b0, 8'h00, 1'b0};
      vec[15] = '{1'b0, 3'd4, 1'b1, 1'b1, 8'h80, 1'b1};
      vec[16] = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0};

      // reset state
      @(negedge clk);
      @(negedge clk);
      check("reset active", 32'(ifc.active), 32'd0);
      check("reset busy", 32'(ifc.busy), 32'd0);
      check("reset address_valid", 32'(ifc.address_valid), 32'd0);
      check("reset wave_address", 32'(ifc.wave_address), 32'd0);
      check("reset frame_done", 32'(ifc.frame_done), 32'd0);
      check("reset overrun", 32'(ifc.overrun), 32'd0);
      nreset = 1'b1;

      // frame sweep, key_on=0: sample current cycle, then drive its inputs
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         check($sformatf("sweep row %0d {act,busy,vld,addr,done}", i),
               32'({ifc.active, ifc.busy, ifc.address_valid, ifc.wave_address, ifc.frame_done}),
               32'({vec[i].act, vec[i].busy, vec[i].valid, vec[i].addr, vec[i].done}));
         ifc.tick = vec[i].tick;
      end

      // reset asserted during channel 2 CALC (cycle T+8)
      @(negedge clk);
      ifc.tick = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         ifc.tick = 1'b0;
      end
      check("midreset pre {act,busy,vld}",
            32'({ifc.active, ifc.busy, ifc.address_valid}), 32'({3'd2, 1'b1, 1'b0}));
      nreset = 1'b0;
      @(negedge clk);
      check("midreset outputs",
            32'({ifc.active, ifc.busy, ifc.address_valid, ifc.wave_address, ifc.frame_done, ifc.overrun}),
            32'd0);
      nreset = 1'b1;
      vcount = 0;
      repeat (10) begin
         @(negedge clk);
         if (ifc.address_valid) vcount++;
      end
      check("midreset no address_valid", 32'(vcount), 32'd0);

      // divider: ch0 freq 10, pointer advances every 11 ticks
      reset_pulse();
      chan_freq[0] = 12'h00A;
      ifc.key_on = 5'b00001;
      for (int f = 1; f <= 23; f++) begin
         run_frame();
         case (f)
            1:  check("divide tick1", 32'(frame_addr[0]), 32'h01);
            2:  check("divide tick2", 32'(frame_addr[0]), 32'h01);
            11: check("divide tick11", 32'(frame_addr[0]), 32'h01);
            12: check("divide tick12", 32'(frame_addr[0]), 32'h02);
            23: check("divide tick23", 32'(frame_addr[0]), 32'h03);
            default: ;
         endcase
      end

      // halt below MIN_FREQ, then key-off
      reset_pulse();
      chan_freq[0] = 12'h000;
      chan_freq[1] = 12'h00A;
      ifc.key_on = 5'b00010;
      run_frame();
      check("halt run ch1", 32'(frame_addr[1]), 32'h21);
      chan_freq[1] = 12'h005;
      for (int f = 0; f < 3; f++) begin
         run_frame();
         check($sformatf("halt frozen %0d", f), 32'(frame_addr[1]), 32'h21);
      end
      ifc.key_on = 5'b00000;
      run_frame();
      check("keyoff ch1", 32'(frame_addr[1]), 32'h20);

      // wrap: ch3 freq 9 advances every 10 ticks, pointer 31 at tick 301
      reset_pulse();
      chan_freq[1] = 12'h000;
      chan_freq[3] = 12'h009;
      ifc.key_on = 5'b01000;
      for (int f = 1; f <= 311; f++) begin
         run_frame();
         case (f)
            300: check("wrap tick300", 32'(frame_addr[3]), 32'h7E);
            301: check("wrap tick301", 32'(frame_addr[3]), 32'h7F);
            310: check("wrap tick310", 32'(frame_addr[3]), 32'h7F);
            311: check("wrap tick311", 32'(frame_addr[3]), 32'h60);
            default: ;
         endcase
      end

      // ticks at T, T+4, T+8
      reset_pulse();
      chan_freq[3] = 12'h000;
      ifc.key_on = 5'b00000;
      vcount = 0;
      dcount = 0;
      for (int i = 0; i <= 40; i++) begin
         @(negedge clk);
         if (ifc.address_valid) vcount++;
         if (ifc.frame_done) dcount++;
`ifdef WTS_SEQ_OVERRUN_EN
         if (i == 9) check("overrun set", 32'(ifc.overrun), 32'd1);
         if (i == 17) check("restart busy T+17", 32'(ifc.busy), 32'd1);
         if (i == 40) check("overrun sticky", 32'(ifc.overrun), 32'd1);
`else
         if (i == 9) check("overrun tied", 32'(ifc.overrun), 32'd0);
         if (i == 17) check("no restart T+17", 32'(ifc.busy), 32'd0);
         if (i == 40) check("overrun still 0", 32'(ifc.overrun), 32'd0);
`endif
         if (i == 16) check("idle gap T+16", 32'(ifc.busy), 32'd0);
         ifc.tick = (i == 0 || i == 4 || i == 8) ? 1'b1 : 1'b0;
      end
`ifdef WTS_SEQ_OVERRUN_EN
      check("overrun valid count", 32'(vcount), 32'd10);
      check("overrun frame_done count", 32'(dcount), 32'd2);
`else
      check("dropped valid count", 32'(vcount), 32'd5);
      check("dropped frame_done count", 32'(dcount), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
